fill_sequencer: RTL and testbench

FILL_SEQUENCER -- requirements
Module: fill_sequencer

---
 rtl/fill_if.sv | 26 ++
 rtl/fill_sequencer.sv | 111 +++++++++++
 tb/tb_fill_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fill_if.sv
// Handshake and status bundle between a fill controller and the fill_sequencer.
// The master side issues requests and unit pulses; the slave side reports progress.
interface fill_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 8
);
    logic                    startWork;
    logic                    stopWork;
    logic                    clrFault;
    logic [N_CH-1:0]         pulseIn;
    logic                    isWork;
    logic [N_CH-1:0]         chFull;
    logic                    allFull;
    logic [N_CH*CNT_W-1:0]   bottleCnt;
    logic                    fault;

    modport master (
        output startWork, stopWork, clrFault, pulseIn,
        input  isWork, chFull, allFull, bottleCnt, fault
    );

    modport slave (
        input  startWork, stopWork, clrFault, pulseIn,
        output isWork, chFull, allFull, bottleCnt, fault
    );
endinterface

// File: rtl/fill_sequencer.sv
// Multi-channel bottle filling sequencer: counts dispensed units into bottles per channel,
// tracks full channels, and supervises the run with an idle-pulse timeout.
module fill_sequencer #(
    parameter int unsigned N_CH             = 4,
    parameter int unsigned PILLS_PER_BOTTLE = 10,
    parameter int unsigned BOTTLES          = 8,
    parameter int unsigned TIMEOUT          = 1000,
    parameter int unsigned CNT_W            = 8
) (
    input logic  CLK,
    input logic  RST,
    fill_if.slave bus
);

    localparam int unsigned UW = (PILLS_PER_BOTTLE > 1) ? $clog2(PILLS_PER_BOTTLE) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    localparam logic [UW-1:0]    UNIT_LAST  = UW'(PILLS_PER_BOTTLE - 1);
    localparam logic [CNT_W-1:0] BOTTLE_MAX = CNT_W'(BOTTLES);
    localparam logic [TW-1:0]    TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWork, StDone, StFault} state_e;

    state_e                       state_q, state_d;
    logic [N_CH-1:0][UW-1:0]      unit_q, unit_d;
    logic [N_CH-1:0][CNT_W-1:0]   bottle_q, bottle_d;
    logic [N_CH-1:0]              full_q, full_d;
    logic [TW-1:0]                tmo_q, tmo_d;

    logic [N_CH-1:0] accept;
    logic            all_full;
    logic            clear_all;

    assign accept    = bus.pulseIn & ~full_q & {N_CH{state_q == StWork}};
    assign all_full  = &full_q;
    assign clear_all = (state_q == StDone) && bus.startWork;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.startWork && !bus.stopWork) state_d = StWork;
            end
            StWork: begin
                // Pause beats completion, completion beats timeout.
                if (bus.stopWork)                                 state_d = StIdle;
                else if (all_full)                                state_d = StDone;
                else if ((accept == '0) && (tmo_q == TMO_LAST))   state_d = StFault;
            end
            StDone: begin
                if (bus.startWork) state_d = StWork;
            end
            StFault: begin
                if (bus.clrFault) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        unit_d   = unit_q;
        bottle_d = bottle_q;
        full_d   = full_q;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (clear_all) begin
                unit_d[i]   = '0;
                bottle_d[i] = '0;
                full_d[i]   = 1'b0;
            end else if (accept[i]) begin
                if (unit_q[i] == UNIT_LAST) begin
                    unit_d[i]   = '0;
                    bottle_d[i] = bottle_q[i] + CNT_W'(1);
                    // Full blocks further pulses, so the count saturates at BOTTLES.
                    if ((bottle_q[i] + CNT_W'(1)) == BOTTLE_MAX) full_d[i] = 1'b1;
                end else begin
                    unit_d[i] = unit_q[i] + UW'(1);
                end
            end
        end
    end

    always_comb begin
        tmo_d = '0;
        if ((state_q == StWork) && (state_d == StWork) && (accept == '0)) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            unit_q   <= '0;
            bottle_q <= '0;
            full_q   <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            unit_q   <= unit_d;
            bottle_q <= bottle_d;
            full_q   <= full_d;
            tmo_q    <= tmo_d;
        end
    end

    assign bus.isWork    = (state_q == StWork);
    assign bus.fault     = (state_q == StFault);
    assign bus.chFull    = full_q;
    assign bus.allFull   = all_full;
    assign bus.bottleCnt = bottle_q;

endmodule

// File: tb/tb_fill_sequencer.sv
// Self-checking bench for fill_sequencer: directed vector table, timeout/reset sequences,
// and randomized traffic compared against a pulse-total reference model.
module tb_fill_sequencer;

    localparam int unsigned N_CH = 2;
    localparam int unsigned PPB  = 3;
    localparam int unsigned BOT  = 2;
    localparam int unsigned TMO  = 5;
    localparam int unsigned CW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fill_if #(.N_CH(N_CH), .CNT_W(CW)) bus ();

    fill_sequencer #(
        .N_CH(N_CH), .PILLS_PER_BOTTLE(PPB), .BOTTLES(BOT), .TIMEOUT(TMO), .CNT_W(CW)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       start;
        logic       stop;
        logic [1:0] pulse;
        logic       is_work;
        logic [1:0] full;
        logic       all_full;
        int         bc0;
        int         bc1;
    } vec_t;

    vec_t vecs[28];

    // Reference model: total accepted units per channel and a coarse mode.
    int m_mode;   // 0 idle, 1 work, 2 done, 3 fault
    int m_tot[2];
    int m_idle;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic s, input logic p, input logic c, input logic [1:0] pl);
        bus.startWork = s;
        bus.stopWork  = p;
        bus.clrFault  = c;
        bus.pulseIn   = pl;
        @(posedge clk);
        #1;
    endtask

    function automatic int bc_of(input int ch);
        int b;
        b = m_tot[ch] / PPB;
        return (b > BOT) ? BOT : b;
    endfunction

    function automatic bit full_of(input int ch);
        return m_tot[ch] >= PPB * BOT;
    endfunction

    task automatic model_step(input logic r, input logic s, input logic p, input logic c,
                              input logic [1:0] pl);
        bit acc[2];
        bit any;
        bit allf;
        if (r) begin
            m_mode = 0; m_tot[0] = 0; m_tot[1] = 0; m_idle = 0;
            return;
        end
        case (m_mode)
            0: if (s && !p) begin m_mode = 1; m_idle = 0; end
            1: begin
                allf = full_of(0) && full_of(1);
                any  = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    acc[i] = pl[i] && !full_of(i);
                    any    = any | acc[i];
                end
                for (int i = 0; i < 2; i++) if (acc[i]) m_tot[i] = m_tot[i] + 1;
                if (p)                              m_mode = 0;
                else if (allf)                      m_mode = 2;
                else if (!any && m_idle == TMO - 1) m_mode = 3;
                m_idle = (m_mode == 1 && !any) ? m_idle + 1 : 0;
            end
            2: if (s) begin m_tot[0] = 0; m_tot[1] = 0; m_mode = 1; m_idle = 0; end
            default: if (c) m_mode = 0;
        endcase
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_isWork"}, int'(bus.isWork), int'(m_mode == 1));
        chk({tag, "_fault"}, int'(bus.fault), int'(m_mode == 3));
        chk({tag, "_chFull"}, int'(bus.chFull), int'({full_of(1), full_of(0)}));
        chk({tag, "_allFull"}, int'(bus.allFull), int'(full_of(0) && full_of(1)));
        chk({tag, "_bc0"}, int'(bus.bottleCnt[0 +: CW]), bc_of(0));
        chk({tag, "_bc1"}, int'(bus.bottleCnt[CW +: CW]), bc_of(1));
    endtask

    initial begin
        int cyc;
        logic r, s, p, c;
        logic [1:0] pl;

        //          start stop pulse  isW full aF bc0 bc1
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 0, 0};
        vecs[1]  = '{1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 0, 0};
        vecs[2]  = '{1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 0, 0};
        vecs[3]  = '{1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 1, 0};
        vecs[4]  = '{1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 1, 0};
        vecs[5]  = '{1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 1, 0};
        vecs[6]  = '{1'b0, 1'b0, 2'b01, 1'b1, 2'b01, 1'b0, 2, 0};
        vecs[7]  = '{1'b0, 1'b0, 2'b10, 1'b1, 2'b01, 1'b0, 2, 0};
        vecs[8]  = '{1'b0, 1'b0, 2'b10, 1'b1, 2'b01, 1'b0, 2, 0};
        vecs[9]  = '{1'b0, 1'b0, 2'b10, 1'b1, 2'b01, 1'b0, 2, 1};
        vecs[10] = '{1'b0, 1'b0, 2'b10, 1'b1, 2'b01, 1'b0, 2, 1};
        vecs[11] = '{1'b0, 1'b0, 2'b10, 1'b1, 2'b01, 1'b0, 2, 1};
        vecs[12] = '{1'b0, 1'b0, 2'b11, 1'b1, 2'b11, 1'b1, 2, 2};
        vecs[13] = '{1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 1'b1, 2, 2};
        vecs[14] = '{1'b0, 1'b0, 2'b01, 1'b0, 2'b11, 1'b1, 2, 2};
        vecs[15] = '{1'b1, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 0, 0};
        vecs[16] = '{1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 0, 0};
        vecs[17] = '{1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 0, 0};
        vecs[18] = '{1'b1, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 0, 0};
        vecs[19] = '{1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 0, 0};
        vecs[20] = '{1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 0, 0};
        vecs[21] = '{1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 0, 0};
        vecs[22] = '{1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 0, 0};
        vecs[23] = '{1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 0, 0};
        vecs[24] = '{1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 0, 0};
        vecs[25] = '{1'b1, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 0, 0};
        vecs[26] = '{1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 1, 0};
        vecs[27] = '{1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1, 0};

        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 2'b11);
        step(1'b0, 1'b0, 1'b0, 2'b00);
        rst = 1'b0;
        chk("reset_isWork", int'(bus.isWork), 0);
        chk("reset_fault", int'(bus.fault), 0);
        chk("reset_allFull", int'(bus.allFull), 0);
        chk("reset_chFull", int'(bus.chFull), 0);
        chk("reset_bottleCnt", int'(bus.bottleCnt), 0);

        for (int k = 0; k < 28; k++) begin
            step(vecs[k].start, vecs[k].stop, 1'b0, vecs[k].pulse);
            chk($sformatf("vec%0d_isWork", k), int'(bus.isWork), int'(vecs[k].is_work));
            chk($sformatf("vec%0d_fault", k), int'(bus.fault), 0);
            chk($sformatf("vec%0d_chFull", k), int'(bus.chFull), int'(vecs[k].full));
            chk($sformatf("vec%0d_allFull", k), int'(bus.allFull), int'(vecs[k].all_full));
            chk($sformatf("vec%0d_bc0", k), int'(bus.bottleCnt[0 +: CW]), vecs[k].bc0);
            chk($sformatf("vec%0d_bc1", k), int'(bus.bottleCnt[CW +: CW]), vecs[k].bc1);
        end

        // Timeout: fault exactly TMO edges after isWork rises.
        step(1'b1, 1'b0, 1'b0, 2'b00);
        chk("tmo_isWork", int'(bus.isWork), 1);
        cyc = 0;
        while (!bus.fault && cyc < 20) begin
            step(1'b0, 1'b0, 1'b0, 2'b00);
            cyc++;
        end
        chk("tmo_cycles", cyc, TMO);
        chk("tmo_isWork_off", int'(bus.isWork), 0);
        step(1'b1, 1'b0, 1'b0, 2'b11);
        step(1'b1, 1'b0, 1'b0, 2'b11);
        chk("fault_holds", int'(bus.fault), 1);
        chk("fault_noWork", int'(bus.isWork), 0);
        chk("fault_bc0", int'(bus.bottleCnt[0 +: CW]), 1);
        step(1'b0, 1'b0, 1'b1, 2'b00);
        chk("clr_fault", int'(bus.fault), 0);
        chk("clr_isWork", int'(bus.isWork), 0);
        chk("clr_bc0", int'(bus.bottleCnt[0 +: CW]), 1);

        // Reset mid-WORK wins over simultaneous start and pulses.
        step(1'b1, 1'b0, 1'b0, 2'b00);
        chk("rst_pre_isWork", int'(bus.isWork), 1);
        chk("rst_pre_bc0", int'(bus.bottleCnt[0 +: CW]), 1);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 2'b01);
        rst = 1'b0;
        chk("rst_isWork", int'(bus.isWork), 0);
        chk("rst_fault", int'(bus.fault), 0);
        chk("rst_chFull", int'(bus.chFull), 0);
        chk("rst_allFull", int'(bus.allFull), 0);
        chk("rst_bottleCnt", int'(bus.bottleCnt), 0);
        step(1'b0, 1'b0, 1'b0, 2'b01);
        chk("rst_idle_isWork", int'(bus.isWork), 0);
        chk("rst_idle_bc", int'(bus.bottleCnt), 0);

        // Randomized traffic against the reference model.
        rst = 1'b1;
        model_step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b0, 2'b00);
        rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 149) == 0);
            s  = ($urandom_range(0, 2) == 0);
            p  = ($urandom_range(0, 9) == 0);
            c  = ($urandom_range(0, 3) == 0);
            pl[0] = ($urandom_range(0, 3) != 0);
            pl[1] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) pl = 2'b00;
            model_step(r, s, p, c, pl);
            rst = r;
            step(s, p, c, pl);
            rst = 1'b0;
            chk_model("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
